// File: rtl/edid_ddc_responder_pkg.sv
// Shared constants, state encodings and helpers for the EDID DDC responder.
package edid_ddc_responder_pkg;

   // Standard DDC/EDID slave address (0xA0 write / 0xA1 read).
   localparam logic [6:0] EDID_DEV_ADDR      = 7'h50;

   // Consecutive equal samples needed before a line change is believed.
   localparam int         FILTER_LEN_DEFAULT = 3;

   // Bit counter value reached once a full byte has been clocked.
   localparam logic [3:0] BIT_CNT_BYTE       = 4'd8;

   // Responder protocol states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WADDR     = 3'd3,
      ST_WAIT_SR   = 3'd4,
      ST_TX        = 3'd5,
      ST_TX_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } ddc_state_t;

   // Byte pointer advance; 8-bit arithmetic so 0xFF wraps to 0x00.
   function automatic logic [7:0] ptr_inc(input logic [7:0] i_ptr);
      return i_ptr + 8'd1;
   endfunction

endpackage

// File: rtl/edid_ddc_responder_i2c_line_filter.sv
// Two-flop synchroniser plus persistence filter for one I2C line.
// A new level is accepted only after FILTER_LEN consecutive equal samples;
// the accepted level and single-cycle rise/fall pulses are registered.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic i_gclk,
   input  logic i_rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int             CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   logic             r_sync0;
   logic             r_sync1;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise the pin, then only accept a level that persists long enough.
   always_ff @(posedge i_gclk or negedge i_rst) begin
      if (!i_rst) begin
         // Idle I2C lines are pulled high, so start from 1 to avoid fake edges.
         r_sync0 <= 1'b1;
         r_sync1 <= 1'b1;
         r_level <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync0 <= i_line;
         r_sync1 <= r_sync0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         if (r_sync1 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_level <= r_sync1;
            r_rise  <= r_sync1;
            r_fall  <= ~r_sync1;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/edid_ddc_responder.sv
// DDC (I2C) slave that serves a 256-byte EDID image to the video source.
// Supports word-address write, repeated-START read, auto-increment and
// current-address reads. Writes of data bytes are refused (read-only).
module edid_ddc_responder
   import edid_ddc_responder_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = EDID_DEV_ADDR,
   parameter int         FILTER_LEN = FILTER_LEN_DEFAULT
) (
   input  logic       gclk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic       enable,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_q,
   output logic       busy,
   output logic       byte_sent
);

   logic       w_scl_level;
   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_sda_level;
   logic       w_sda_rise;
   logic       w_sda_fall;
   logic       w_start;
   logic       w_stop;

   ddc_state_t r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_ptr;
   logic       r_sda_oe;
   logic       r_busy;
   logic       r_byte_sent;
   logic       r_rw;
   logic       r_master_ack;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .i_gclk  (gclk),
      .i_rst   (rst),
      .i_line  (scl),
      .o_level (w_scl_level),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .i_gclk  (gclk),
      .i_rst   (rst),
      .i_line  (sda),
      .o_level (w_sda_level),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   // An SDA edge only counts as START/STOP when SCL is high and not itself
   // changing in the same filtered sample.
   assign w_start = w_sda_fall && w_scl_level && !w_scl_rise;
   assign w_stop  = w_sda_rise && w_scl_level && !w_scl_rise;

   // Open-drain pad: pull low or let go, never drive high. Async reset
   // clears r_sda_oe, so the line is released immediately.
   assign sda       = r_sda_oe ? 1'b0 : 1'bz;
   assign mem_addr  = r_ptr;
   assign busy      = r_busy;
   assign byte_sent = r_byte_sent;

   // Protocol FSM with bit counter, shift register, pointer and pad control.
   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 8'd0;
         r_ptr        <= 8'd0;
         r_sda_oe     <= 1'b0;
         r_busy       <= 1'b0;
         r_byte_sent  <= 1'b0;
         r_rw         <= 1'b0;
         r_master_ack <= 1'b0;
      end else begin
         r_byte_sent <= 1'b0;
         if (w_stop) begin
            r_state   <= ST_IDLE;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_bit_cnt <= 4'd0;
         end else if (w_start) begin
            // Repeated START keeps busy: the session is still ours.
            r_state   <= ST_ADDR;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_sda_oe <= 1'b0;
               end

               ST_ADDR: begin
                  if (w_scl_rise && r_bit_cnt != BIT_CNT_BYTE) begin
                     r_shift   <= {r_shift[6:0], w_sda_level};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == BIT_CNT_BYTE) begin
                     r_bit_cnt <= 4'd0;
                     if (enable && r_shift[7:1] == DEV_ADDR) begin
                        r_sda_oe <= 1'b1;
                        r_busy   <= 1'b1;
                        r_rw     <= r_shift[0];
                        r_state  <= ST_ADDR_ACK;
                     end else begin
                        // Not addressed (or EDID not ready): stay silent.
                        r_busy  <= 1'b0;
                        r_state <= ST_WAIT_STOP;
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     r_bit_cnt <= 4'd0;
                     if (r_rw) begin
                        // mem_addr has been stable for a whole SCL phase,
                        // so mem_q already reflects it.
                        r_shift     <= mem_q;
                        r_sda_oe    <= ~mem_q[7];
                        r_byte_sent <= 1'b1;
                        r_ptr       <= ptr_inc(r_ptr);
                        r_state     <= ST_TX;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_WADDR;
                     end
                  end
               end

               ST_WADDR: begin
                  if (w_scl_rise && r_bit_cnt != BIT_CNT_BYTE) begin
                     r_shift   <= {r_shift[6:0], w_sda_level};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == BIT_CNT_BYTE) begin
                     if (!r_sda_oe) begin
                        // Falling edge after 8th bit: start the ACK.
                        r_sda_oe <= 1'b1;
                     end else begin
                        // Falling edge ending the ACK: commit the pointer.
                        r_sda_oe  <= 1'b0;
                        r_ptr     <= r_shift;
                        r_bit_cnt <= 4'd0;
                        r_state   <= ST_WAIT_SR;
                     end
                  end
               end

               ST_WAIT_SR: begin
                  // Anything other than a repeated START is a write attempt;
                  // clock it in and refuse it.
                  if (w_scl_rise && r_bit_cnt != BIT_CNT_BYTE) begin
                     r_shift   <= {r_shift[6:0], w_sda_level};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == BIT_CNT_BYTE) begin
                     r_bit_cnt <= 4'd0;
                     r_busy    <= 1'b0;
                     r_state   <= ST_WAIT_STOP;
                  end
               end

               ST_TX: begin
                  if (w_scl_rise && r_bit_cnt != BIT_CNT_BYTE) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == BIT_CNT_BYTE) begin
                        r_sda_oe  <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= ST_TX_ACK;
                     end else begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_sda_oe <= ~r_shift[6];
                     end
                  end
               end

               ST_TX_ACK: begin
                  if (w_scl_rise) begin
                     r_master_ack <= ~w_sda_level;
                  end else if (w_scl_fall) begin
                     if (r_master_ack) begin
                        r_shift     <= mem_q;
                        r_sda_oe    <= ~mem_q[7];
                        r_byte_sent <= 1'b1;
                        r_ptr       <= ptr_inc(r_ptr);
                        r_state     <= ST_TX;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_WAIT_STOP;
                     end
                  end
               end

               ST_WAIT_STOP: begin
                  r_sda_oe <= 1'b0;
               end

               default: begin
                  r_state  <= ST_IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
